// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: parses a MIDI byte stream into a monophonic note, a gate and an oscillator phase increment
module midi_note_ctrl #(
  parameter int          ACC_WIDTH = 24,
  parameter int unsigned CHANNEL   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [ACC_WIDTH-1:0] phase_inc,
  output logic                 gate,
  output logic [6:0]           note,
  output logic [6:0]           velocity,
  output logic                 note_strobe
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  logic [1:0]  state;
  logic [3:0]  rs_type;
  logic        rs_two;
  logic        rs_match;
  logic [6:0]  d1;
  logic        is_sys;
  logic        is_cv;
  logic        is_data;
  logic        done;
  logic [6:0]  m1;
  logic [6:0]  m2;
  logic [6:0]  oct;
  logic [6:0]  semi;
  logic [12:0] base;
  logic [12:0] inc;
  logic        note_on;
  logic        note_off;
  logic        all_off;
  // 0xF8-0xFF match none of these classes, so real-time bytes fall through untouched
  assign is_data  = rx_valid & ~rx_data[7];
  assign is_sys   = rx_valid & (rx_data[7:3] == 5'h1E);
  assign is_cv    = rx_valid & rx_data[7] & (rx_data[7:4] != 4'hF);
  assign done     = is_data & ((state == WAIT_D1 & ~rs_two) | state == WAIT_D2);
  assign m1       = state == WAIT_D2 ? d1 : rx_data[6:0];
  assign m2       = rx_data[6:0];
  assign note_on  = done & rs_match & rs_type == 4'h9 & m2 != 7'd0;
  assign note_off = done & rs_match & (rs_type == 4'h8 | (rs_type == 4'h9 & m2 == 7'd0)) & m1 == note;
  assign all_off  = done & rs_match & rs_type == 4'hB & m1 == 7'd123;
  assign oct      = m1 / 7'd12;
  assign semi     = m1 % 7'd12;
  // top-octave increments, halved once per octave below note 120
  always_comb begin
    base = 13'd0;
    case (semi)
      7'd0:    base = 13'd2809;
      7'd1:    base = 13'd2976;
      7'd2:    base = 13'd3153;
      7'd3:    base = 13'd3341;
      7'd4:    base = 13'd3539;
      7'd5:    base = 13'd3750;
      7'd6:    base = 13'd3973;
      7'd7:    base = 13'd4209;
      7'd8:    base = 13'd4459;
      7'd9:    base = 13'd4724;
      7'd10:   base = 13'd5005;
      7'd11:   base = 13'd5303;
      default: base = 13'd0;
    endcase
  end
  assign inc = base >> (7'd10 - oct);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rs_type     <= 4'd0;
      rs_two      <= 1'b0;
      rs_match    <= 1'b0;
      d1          <= 7'd0;
      phase_inc   <= '0;
      gate        <= 1'b0;
      note        <= 7'd0;
      velocity    <= 7'd0;
      note_strobe <= 1'b0;
    end else begin
      note_strobe <= note_on;
      if (is_sys) begin
        state    <= IDLE;
        rs_type  <= 4'd0;
        rs_two   <= 1'b0;
        rs_match <= 1'b0;
      end else if (is_cv) begin
        state    <= WAIT_D1;
        rs_type  <= rx_data[7:4];
        rs_two   <= rx_data[7:5] != 3'b110;
        rs_match <= (rx_data[7:4] == 4'h8 | rx_data[7:4] == 4'h9 | rx_data[7:4] == 4'hB) & rx_data[3:0] == 4'(CHANNEL);
      end else if (is_data & state != IDLE) begin
        d1    <= rx_data[6:0];
        state <= (state == WAIT_D1 & rs_two) ? WAIT_D2 : WAIT_D1;
      end
      if (note_on) begin
        note      <= m1;
        velocity  <= m2;
        gate      <= 1'b1;
        phase_inc <= ACC_WIDTH'(inc);
      end else if (note_off | all_off) begin
        gate <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_midi_note_ctrl.sv
// tb_midi_note_ctrl: directed byte sequences with hand-computed note/pitch/gate expectations
module tb_midi_note_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [23:0] phase_inc;
  logic        gate;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic        note_strobe;
  int checks = 0;
  int failures = 0;
  midi_note_ctrl #(.ACC_WIDTH(24), .CHANNEL(0)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .phase_inc(phase_inc), .gate(gate), .note(note), .velocity(velocity), .note_strobe(note_strobe)
  );
  always #10 clk = ~clk;
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int inc, input int g, input int n, input int v, input int s);
    chk({tag, ".phase_inc"}, 32'(phase_inc), 32'(inc));
    chk({tag, ".gate"}, 32'(gate), 32'(g));
    chk({tag, ".note"}, 32'(note), 32'(n));
    chk({tag, ".velocity"}, 32'(velocity), 32'(v));
    chk({tag, ".strobe"}, 32'(note_strobe), 32'(s));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    send(8'h45); idle();
    chk_all("stray_after_reset", 0, 0, 0, 0, 0);
    send(8'h90); send(8'h45); send(8'h64); idle();
    chk_all("note_on_69", 147, 1, 69, 100, 1);
    idle();
    chk("strobe_one_cycle", 32'(note_strobe), 0);
    send(8'h3C); send(8'h40); idle();
    chk_all("running_60", 87, 1, 60, 64, 1);
    idle();
    send(8'h80); send(8'h45); send(8'h00); idle();
    chk_all("off_other_note", 87, 1, 60, 64, 0);
    send(8'h90); send(8'h3C); send(8'h00); idle();
    chk_all("vel0_off", 87, 0, 60, 64, 0);
    send(8'h90); send(8'hF8); send(8'h40); send(8'hFE); send(8'h7F); idle();
    chk_all("realtime_64", 110, 1, 64, 127, 1);
    send(8'h91); send(8'h30); send(8'h40); idle();
    chk_all("other_channel", 110, 1, 64, 127, 0);
    send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h40); idle();
    chk_all("after_pc_48", 43, 1, 48, 64, 1);
    send(8'h90); send(8'h7F); send(8'h01); idle();
    chk_all("note_127", 4209, 1, 127, 1, 1);
    send(8'h00); send(8'h02); idle();
    chk_all("note_0", 2, 1, 0, 2, 1);
    send(8'hB0); send(8'h07); send(8'h10); idle();
    chk_all("cc_other", 2, 1, 0, 2, 0);
    send(8'hB0); send(8'h7B); send(8'h00); idle();
    chk_all("all_notes_off", 2, 0, 0, 2, 0);
    send(8'h90); send(8'h3C); send(8'h40); idle();
    chk_all("reon_60", 87, 1, 60, 64, 1);
    send(8'h3C); send(8'h50); idle();
    chk_all("repeat_60", 87, 1, 60, 80, 1);
    send(8'hF0); send(8'h45); send(8'h50); idle();
    chk_all("sysex_cancel", 87, 1, 60, 80, 0);
    send(8'h90); send(8'h30); idle();
    #1 reset_n = 1'b0;
    #1 chk_all("reset_mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h40); send(8'h45); idle();
    chk_all("post_reset_data", 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
